fx_mul_pipe: RTL and testbench
==============================

Name: fx_mul_pipe

Overview:
Parametrised signed fixed-point multiplier, successor to the fixed-latency QMC-LSM multiplier. Adds a valid/ready stream handshake with full backpressure, selectable rounding, an overflow flag, optional saturation and a pass-through tag. It sits between the path generator and the regression/discount datapath, where downstream stalls are possible.

Parameters:
WIDTH, 32, operand/result width in bits
QINT, 16, integer bits including sign
QFRAC, WIDTH-QINT, fractional bits; QFRAC >= 1
LATENCY, 3, accept-to-output cycles when not stalled; must be >= 2
TAG_W, 8, width of the sideband tag carried alongside each operand pair

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  signed operand, Q(QINT).(QFRAC)
in_b  in  WIDTH  signed operand, Q(QINT).(QFRAC)
in_rnd  in  1  0 = truncate (floor), 1 = round-half-up; sampled with the data
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_p  out  WIDTH  product, Q(QINT).(QFRAC)
out_ovf  out  1  result exceeded the representable range
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: only clk and rst are named by codebase convention; rst is synchronous and active-high.
  - While rst is high at a clock edge, all stage valid bits are cleared.
  - out_valid=0, out_p=0, out_ovf=0, out_tag=0.
  - Operations in flight are discarded; no output appears for them.
  - in_ready=1 in the first cycle after reset is released.
- Pipeline: LATENCY stages, each holding {valid, data, rnd, tag}.
  - Stage 1: input register.
  - Stages 2..LATENCY-1: full 2*WIDTH signed product, registered through.
  - Stage LATENCY: round/shift/overflow/saturate, then drives the out_* ports.
- Stall and acceptance:
  - adv = !out_valid || out_ready. The whole pipeline advances only when adv=1.
  - Internal bubbles are not compressed.
  - in_ready = adv, combinational.
  - A transfer happens when in_valid && in_ready.
- Output handshake:
  - While out_valid=1 and out_ready=0, out_p, out_ovf and out_tag are held stable.
  - Once asserted, out_valid stays high until a transfer.
- Latency: with out_ready held at 1, a pair accepted at edge N is presented at edge N+LATENCY. Throughput is 1 per cycle.
- Simultaneous events: an output transfer and an input accept in the same cycle are both legal, with no gap.
- Arithmetic:
  - P = a*b, computed in 2*WIDTH bits with 2*QFRAC fractional bits.
  - Rounding, when in_rnd=1: R = P + 2^(QFRAC-1), computed in 2*WIDTH+1 bits so the add cannot wrap.
  - Shift: S = R >>> QFRAC (arithmetic). Truncation is floor, including for negatives.
  - out_ovf = 1 unless S[2*WIDTH:WIDTH-1] are all equal.
- Result on overflow: see the optional feature. Without overflow, out_p = S[WIDTH-1:0].
- Edge case: the most-negative operand squared (0x80000000*0x80000000) overflows and is flagged.

Optional Feature:
- Macro: FX_MUL_SAT_EN.
- Defined: on overflow, out_p saturates.
  - 2^(WIDTH-1)-1 (0x7FFFFFFF) if S is positive.
  - -2^(WIDTH-1) (0x80000000) if S is negative.
- Undefined: out_p = S[WIDTH-1:0] (wrap). out_ovf is still reported.

Decomposition:
- Package fx_pkg holds:
  - typedef fx_rnd_e {FX_RND_TRUNC=0, FX_RND_HALF_UP=1};
  - localparams for the default WIDTH/QINT/QFRAC;
  - function fx_sat_max(width) / fx_sat_min(width).
- Sub-module fx_round_sat: combinational round, shift, overflow detect and saturate (under FX_MUL_SAT_EN). Instantiated inside the final stage so it can be reused by the planned divider.

Test Plan (defaults unless noted):
- Basic product: a=0x00018000 (1.5), b=0x00020000 (2.0), rnd=0, tag=0x5A, out_ready=1 -> exactly 3 cycles later out_p=0x00030000, ovf=0, tag=0x5A.
- Rounding:
  - a=0x00000001, b=0x00008000: rnd=0 -> 0x00000000; rnd=1 -> 0x00000001.
  - a=0xFFFFFFFF, b=0x00008000: rnd=0 -> 0xFFFFFFFF; rnd=1 -> 0x00000000.
- Overflow, a=0x01000000, b=0x01000000:
  - with FX_MUL_SAT_EN -> out_p=0x7FFFFFFF, ovf=1;
  - without -> out_p=0x00000000, ovf=1;
  - a=0xFF000000, b=0x01000000 with SAT -> 0x80000000, ovf=1.
- Backpressure:
  - stream 10 back-to-back pairs with tags 0..9;
  - hold out_ready=0 for 5 cycles mid-stream;
  - expect in_ready=0 while out_valid=1 and out_ready=0, outputs stable, all 10 results in order, no loss or duplication.
- Reset mid-operation: accept 2 pairs, assert rst for 1 cycle before they emerge -> no output appears, out_valid=0, in_ready=1 after reset.
- Parameter sweep: WIDTH=16, QINT=8, LATENCY=2 -> a=0x0180, b=0x0200 gives 0x0300 two cycles after accept. Random stream checked against a reference model.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared types, default Q-format and saturation helpers for the fixed-point blocks.
// FX_MUL_SAT_EN (consumed by fx_round_sat) selects saturating overflow handling.
package fx_pkg;

  typedef enum logic {
    FX_RND_TRUNC   = 1'b0,
    FX_RND_HALF_UP = 1'b1
  } fx_rnd_e;

  localparam int FX_WIDTH = 32;
  localparam int FX_QINT  = 16;
  localparam int FX_QFRAC = FX_WIDTH - FX_QINT;

  // Callers truncate the 64-bit result to their own width.
  function automatic logic [63:0] fx_sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fx_sat_min(input int width);
    return ~fx_sat_max(width);
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round / shift / overflow detect for a double-width Q product.
// With FX_MUL_SAT_EN defined an overflowing result clamps, otherwise it wraps.
module fx_round_sat
  import fx_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int QFRAC = FX_QFRAC
) (
  input  logic [2*WIDTH-1:0] prod,
  input  fx_rnd_e            rnd,
  output logic [WIDTH-1:0]   res,
  output logic               ovf
);

  // One guard bit above the product so the rounding add cannot wrap.
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (QFRAC - 1);

  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic [WIDTH+1:0]     top;

  always_comb begin
    rounded = $signed({prod[2*WIDTH-1], prod});
    if (rnd == FX_RND_HALF_UP) begin
      rounded = rounded + $signed(HALF);
    end
    shifted = rounded >>> QFRAC;
    // Result fits only if every bit from the sign down to bit WIDTH-1 agrees.
    top = shifted[PW-1:WIDTH-1];
    ovf = !((&top) || !(|top));
`ifdef FX_MUL_SAT_EN
    if (ovf) begin
      res = shifted[PW-1] ? WIDTH'(fx_sat_min(WIDTH)) : WIDTH'(fx_sat_max(WIDTH));
    end else begin
      res = shifted[WIDTH-1:0];
    end
`else
    res = shifted[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fx_mul_pipe.sv
// Signed fixed-point multiplier with valid/ready backpressure and a stall-all pipeline.
// Build option FX_MUL_SAT_EN: saturate instead of wrap on overflow (ovf flagged either way).
module fx_mul_pipe
  import fx_pkg::*;
#(
  parameter int WIDTH   = FX_WIDTH,
  parameter int QINT    = FX_QINT,
  parameter int QFRAC   = WIDTH - QINT,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_rnd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int NMID = (LATENCY > 2) ? LATENCY - 2 : 1;

  logic             adv;
  logic             in_v_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  fx_rnd_e          rnd_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [PW-1:0]    prod;

  logic             fin_v;
  logic [PW-1:0]    fin_p;
  fx_rnd_e          fin_rnd;
  logic [TAG_W-1:0] fin_tag;
  logic [WIDTH-1:0] rs_res;
  logic             rs_ovf;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_p_reg;
  logic             out_ovf_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // The whole pipe moves together; bubbles are kept, never squeezed out.
  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_reg <= 1'b0;
    end else if (adv) begin
      in_v_reg <= in_valid;
      a_reg    <= in_a;
      b_reg    <= in_b;
      rnd_reg  <= fx_rnd_e'(in_rnd);
      tag_reg  <= in_tag;
    end
  end

  assign prod = PW'($signed(a_reg)) * PW'($signed(b_reg));

  generate
    if (LATENCY > 2) begin : g_mid
      for (genvar gi = 0; gi < NMID; gi++) begin : g_stage
        logic             v_reg;
        logic [PW-1:0]    p_reg;
        fx_rnd_e          rnd_reg;
        logic [TAG_W-1:0] tag_reg;
        logic             src_v;
        logic [PW-1:0]    src_p;
        fx_rnd_e          src_rnd;
        logic [TAG_W-1:0] src_tag;

        if (gi == 0) begin : g_src
          assign src_v   = in_v_reg;
          assign src_p   = prod;
          assign src_rnd = fx_mul_pipe.rnd_reg;
          assign src_tag = fx_mul_pipe.tag_reg;
        end else begin : g_src
          assign src_v   = g_stage[gi-1].v_reg;
          assign src_p   = g_stage[gi-1].p_reg;
          assign src_rnd = g_stage[gi-1].rnd_reg;
          assign src_tag = g_stage[gi-1].tag_reg;
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            v_reg <= 1'b0;
          end else if (adv) begin
            v_reg   <= src_v;
            p_reg   <= src_p;
            rnd_reg <= src_rnd;
            tag_reg <= src_tag;
          end
        end
      end

      assign fin_v   = g_stage[NMID-1].v_reg;
      assign fin_p   = g_stage[NMID-1].p_reg;
      assign fin_rnd = g_stage[NMID-1].rnd_reg;
      assign fin_tag = g_stage[NMID-1].tag_reg;
    end else begin : g_direct
      // Two-stage build: the multiply feeds the final stage combinationally.
      assign fin_v   = in_v_reg;
      assign fin_p   = prod;
      assign fin_rnd = rnd_reg;
      assign fin_tag = tag_reg;
    end
  endgenerate

  fx_round_sat #(
    .WIDTH(WIDTH),
    .QFRAC(QFRAC)
  ) u_round_sat (
    .prod(fin_p),
    .rnd (fin_rnd),
    .res (rs_res),
    .ovf (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_p_reg     <= '0;
      out_ovf_reg   <= 1'b0;
      out_tag_reg   <= '0;
    end else if (adv) begin
      out_valid_reg <= fin_v;
      out_p_reg     <= rs_res;
      out_ovf_reg   <= rs_ovf;
      out_tag_reg   <= fin_tag;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Bench for fx_mul_pipe: default 32-bit/LATENCY 3 instance plus a 16-bit/LATENCY 2 instance,
// directed steps then randomized traffic checked against an integer-arithmetic reference.
module tb_fx_mul_pipe;

  localparam int W0 = 32, Q0 = 16, L0 = 3;
  localparam int W1 = 16, Q1 = 8,  L1 = 2;
  localparam int TW = 8;

`ifdef FX_MUL_SAT_EN
  localparam logic [63:0] OV_POS = 64'h7FFFFFFF;
  localparam logic [63:0] OV_NEG = 64'h80000000;
`else
  localparam logic [63:0] OV_POS = 64'h0;
  localparam logic [63:0] OV_NEG = 64'h0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid0, in_ready0, in_rnd0, out_valid0, out_ready0, out_ovf0;
  logic [W0-1:0] in_a0, in_b0, out_p0;
  logic [TW-1:0] in_tag0, out_tag0;
  logic          in_valid1, in_ready1, in_rnd1, out_valid1, out_ready1, out_ovf1;
  logic [W1-1:0] in_a1, in_b1, out_p1;
  logic [TW-1:0] in_tag1, out_tag1;

  fx_mul_pipe u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .in_rnd(in_rnd0), .in_tag(in_tag0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0),
    .out_ovf(out_ovf0), .out_tag(out_tag0)
  );

  fx_mul_pipe #(.WIDTH(W1), .QINT(W1 - Q1), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .in_rnd(in_rnd1), .in_tag(in_tag1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_p(out_p1),
    .out_ovf(out_ovf1), .out_tag(out_tag1)
  );

  typedef struct {
    logic [63:0] p;
    logic        ovf;
    logic [7:0]  tag;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          lat_chk = 0;
  bit          acc_flag[2];
  bit          stall[2];
  logic [63:0] held_p[2];
  logic        held_ovf[2];
  logic [7:0]  held_tag[2];
  bit          pend_use[2];
  logic [63:0] pend_p[2];
  logic        pend_ovf[2];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  // Exact integer arithmetic: value = raw / 2^qf, floor after optional +half.
  function automatic logic [64:0] ref_mul(input int w, input int qf, input logic [63:0] a,
                                          input logic [63:0] b, input logic rnd);
    logic signed [127:0] sa, sb, s, hi, lo;
    logic [63:0] mask, p;
    logic ovf;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed({64'd0, a & mask});
    sb = $signed({64'd0, b & mask});
    if (a[w-1]) sa = sa - (128'sd1 <<< w);
    if (b[w-1]) sb = sb - (128'sd1 <<< w);
    s = sa * sb;
    if (rnd) s = s + (128'sd1 <<< (qf - 1));
    s = s >>> qf;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    ovf = (s > hi) || (s < lo);
    p = s[63:0] & mask;
`ifdef FX_MUL_SAT_EN
    if (ovf) p = ((s > hi) ? hi[63:0] : lo[63:0]) & mask;
`endif
    return {ovf, p};
  endfunction

  function automatic logic [63:0] rand_op(input int w, input int qf);
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: begin
        v = 64'($urandom_range(0, (1 << (qf + 2)) - 1));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: begin
        case ($urandom_range(0, 3))
          0: v = 64'd1 << (w - 1);
          1: v = (64'd1 << (w - 1)) - 64'd1;
          2: v = '1;
          default: v = 64'd1 << qf;
        endcase
      end
      default: v = 64'($urandom);
    endcase
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic observe(input int id, input logic iv, input logic ir, input logic [63:0] a,
                         input logic [63:0] b, input logic rnd, input logic [7:0] itag,
                         input logic ov, input logic ordy, input logic [63:0] p,
                         input logic ovf, input logic [7:0] otag);
    int w, qf, lat, qs;
    logic [64:0] r;
    exp_t e;
    w   = (id == 0) ? W0 : W1;
    qf  = (id == 0) ? Q0 : Q1;
    lat = (id == 0) ? L0 : L1;
    acc_flag[id] = iv && ir;
    chk($sformatf("in_ready%0d", id), 64'(ir), 64'(!ov || ordy));
    if (iv && ir) begin
      r     = ref_mul(w, qf, a, b, rnd);
      e.p   = pend_use[id] ? pend_p[id] : r[63:0];
      e.ovf = pend_use[id] ? pend_ovf[id] : r[64];
      e.tag = itag;
      e.acc = cyc;
      pend_use[id] = 0;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (stall[id]) begin
      chk($sformatf("held_valid%0d", id), 64'(ov), 64'd1);
      chk($sformatf("held_p%0d", id), p, held_p[id]);
      chk($sformatf("held_ovf%0d", id), 64'(ovf), 64'(held_ovf[id]));
      chk($sformatf("held_tag%0d", id), 64'(otag), 64'(held_tag[id]));
    end
    if (ov && ordy) begin
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_out%0d: observed result tag %h, expected no result", id, otag);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("p%0d tag=%h", id, e.tag), p, e.p);
        chk($sformatf("ovf%0d tag=%h", id, e.tag), 64'(ovf), 64'(e.ovf));
        chk($sformatf("tag%0d", id), 64'(otag), 64'(e.tag));
        if (lat_chk) chk($sformatf("latency%0d", id), 64'(cyc - e.acc), 64'(lat));
      end
    end
    stall[id]    = ov && !ordy;
    held_p[id]   = p;
    held_ovf[id] = ovf;
    held_tag[id] = otag;
  endtask

  task automatic tick();
    bit r_edge;
    @(negedge clk);
    if (!rst) begin
      observe(0, in_valid0, in_ready0, 64'(in_a0), 64'(in_b0), in_rnd0, in_tag0,
              out_valid0, out_ready0, 64'(out_p0), out_ovf0, out_tag0);
      observe(1, in_valid1, in_ready1, 64'(in_a1), 64'(in_b1), in_rnd1, in_tag1,
              out_valid1, out_ready1, 64'(out_p1), out_ovf1, out_tag1);
    end else begin
      acc_flag[0] = 0;
      acc_flag[1] = 0;
    end
    r_edge = rst;
    @(posedge clk);
    cyc++;
    if (r_edge) begin
      q0.delete();
      q1.delete();
      stall[0] = 0;
      stall[1] = 0;
    end
    #1;
  endtask

  task automatic send(input int id, input logic [63:0] a, input logic [63:0] b, input logic rnd,
                      input logic [7:0] tag, input bit use_exp, input logic [63:0] ep,
                      input logic eovf);
    int k;
    pend_use[id] = use_exp;
    pend_p[id]   = ep;
    pend_ovf[id] = eovf;
    if (id == 0) begin
      in_valid0 = 1; in_a0 = a[W0-1:0]; in_b0 = b[W0-1:0]; in_rnd0 = rnd; in_tag0 = tag;
    end else begin
      in_valid1 = 1; in_a1 = a[W1-1:0]; in_b1 = b[W1-1:0]; in_rnd1 = rnd; in_tag1 = tag;
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (!acc_flag[id] && k < 50);
    if (!acc_flag[id]) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout%0d: observed no accept in 50 cycles, expected accept", id);
    end
    pend_use[id] = 0;
    if (id == 0) in_valid0 = 0; else in_valid1 = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid0", 64'(out_valid0), 64'd0);
    chk("rst_out_p0", 64'(out_p0), 64'd0);
    chk("rst_out_ovf0", 64'(out_ovf0), 64'd0);
    chk("rst_out_tag0", 64'(out_tag0), 64'd0);
    chk("rst_in_ready0", 64'(in_ready0), 64'd1);
    chk("rst_out_valid1", 64'(out_valid1), 64'd0);
    chk("rst_in_ready1", 64'(in_ready1), 64'd1);
  endtask

  initial begin
    in_valid0 = 0; in_a0 = '0; in_b0 = '0; in_rnd0 = 0; in_tag0 = '0; out_ready0 = 1;
    in_valid1 = 0; in_a1 = '0; in_b1 = '0; in_rnd1 = 0; in_tag1 = '0; out_ready1 = 1;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    check_reset_state();

    // Directed values with exact 3-cycle latency
    lat_chk = 1;
    send(0, 64'h00018000, 64'h00020000, 0, 8'h5A, 1, 64'h00030000, 0);
    repeat (4) tick();
    send(0, 64'h00000001, 64'h00008000, 0, 8'h10, 1, 64'h00000000, 0);
    send(0, 64'h00000001, 64'h00008000, 1, 8'h11, 1, 64'h00000001, 0);
    send(0, 64'hFFFFFFFF, 64'h00008000, 0, 8'h12, 1, 64'hFFFFFFFF, 0);
    send(0, 64'hFFFFFFFF, 64'h00008000, 1, 8'h13, 1, 64'h00000000, 0);
    send(0, 64'h01000000, 64'h01000000, 0, 8'h20, 1, OV_POS, 1);
    send(0, 64'hFF000000, 64'h01000000, 0, 8'h21, 1, OV_NEG, 1);
    send(0, 64'h80000000, 64'h80000000, 0, 8'h22, 1, OV_POS, 1);
    repeat (5) tick();

    // Back-to-back stream with a 5-cycle consumer stall
    lat_chk = 0;
    begin
      int i, k;
      bit fresh;
      logic [63:0] v;
      i = 0; k = 0; fresh = 1;
      while (i < 10 && k < 100) begin
        if (fresh) begin
          v = rand_op(W0, Q0); in_a0 = v[W0-1:0];
          v = rand_op(W0, Q0); in_b0 = v[W0-1:0];
          in_rnd0 = 1'($urandom_range(0, 1));
          in_tag0 = 8'(i);
          in_valid0 = 1;
          fresh = 0;
        end
        out_ready0 = !(k >= 3 && k < 8);
        tick();
        k++;
        if (acc_flag[0]) begin
          i++;
          fresh = 1;
        end
      end
      in_valid0 = 0;
      out_ready0 = 1;
      chk("stream_sent", 64'(i), 64'd10);
    end
    repeat (6) tick();
    chk("stream_drained0", 64'(q0.size()), 64'd0);

    // Reset while two operations are in flight
    lat_chk = 1;
    send(0, 64'h00030000, 64'h00020000, 0, 8'hA0, 0, 64'd0, 0);
    send(0, 64'h00050000, 64'h00020000, 0, 8'hA1, 0, 64'd0, 0);
    rst = 1;
    tick();
    rst = 0;
    check_reset_state();
    repeat (5) begin
      tick();
      chk("post_rst_quiet0", 64'(out_valid0), 64'd0);
    end

    // Narrow build: Q8.8, two-stage pipe
    send(1, 64'h0180, 64'h0200, 0, 8'h33, 1, 64'h0300, 0);
    repeat (3) tick();

    // Random traffic on both instances with random backpressure
    lat_chk = 0;
    for (int t = 0; t < 600; t++) begin
      logic [63:0] v;
      if (!in_valid0 || acc_flag[0]) begin
        in_valid0 = ($urandom_range(0, 3) != 0);
        v = rand_op(W0, Q0); in_a0 = v[W0-1:0];
        v = rand_op(W0, Q0); in_b0 = v[W0-1:0];
        in_rnd0 = 1'($urandom_range(0, 1));
        in_tag0 = 8'($urandom);
      end
      if (!in_valid1 || acc_flag[1]) begin
        in_valid1 = ($urandom_range(0, 3) != 0);
        v = rand_op(W1, Q1); in_a1 = v[W1-1:0];
        v = rand_op(W1, Q1); in_b1 = v[W1-1:0];
        in_rnd1 = 1'($urandom_range(0, 1));
        in_tag1 = 8'($urandom);
      end
      out_ready0 = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid0 = 0; in_valid1 = 0; out_ready0 = 1; out_ready1 = 1;
    repeat (8) tick();
    chk("rand_drained0", 64'(q0.size()), 64'd0);
    chk("rand_drained1", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed simulation still running at 1 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
